// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between one requester and the data-memory arbiter.
interface dmem_arbiter_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    modport master (
        output valid, we, addr, wdata,
        input  ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 64-byte data memory:
// one access per grant, registered one-cycle response to the winner.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic [15:0]   mem_Address,
    output logic [15:0]   mem_data_write,
    output logic          mem_MeM_W,
    output logic          mem_MeM_R,
    input  logic [15:0]   mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] MAX_ADDR = 16'(MEM_BYTES - 2);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        win;
    logic        accept;
    logic        addr_err;
    logic        lat_we;
    logic        lat_port;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [15:0] resp_rdata_q;
    logic        resp_err_q;
    logic        resp_live;

    always_comb begin
        win = 1'b0;
        if (p0.valid && p1.valid) begin
            win = ~last_grant;
        end else if (p1.valid) begin
            win = 1'b1;
        end
        accept   = !reset && (state == IDLE) && (p0.valid || p1.valid);
        addr_err = lat_addr > MAX_ADDR;

        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Enables and responses are gated by reset so an access colliding with reset is dropped.
    assign mem_MeM_W = !reset && (state == ACCESS) && lat_we && !addr_err;
    assign mem_MeM_R = !reset && (state == ACCESS) && !lat_we && !addr_err;
    assign mem_Address    = lat_addr;
    assign mem_data_write = lat_wdata;

    assign p0.ready = accept && !win;
    assign p1.ready = accept && win;

    assign resp_live        = !reset && (state == RESP);
    assign p0.resp_valid    = resp_live && !lat_port;
    assign p1.resp_valid    = resp_live && lat_port;
    assign p0.resp_rdata    = p0.resp_valid ? resp_rdata_q : '0;
    assign p1.resp_rdata    = p1.resp_valid ? resp_rdata_q : '0;
    assign p0.resp_err      = p0.resp_valid && resp_err_q;
    assign p1.resp_err      = p1.resp_valid && resp_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            lat_we       <= 1'b0;
            lat_port     <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= win;
                lat_port   <= win;
                lat_we     <= win ? p1.we    : p0.we;
                lat_addr   <= win ? p1.addr  : p0.addr;
                lat_wdata  <= win ? p1.wdata : p0.wdata;
            end
            if (state == ACCESS) begin
                resp_rdata_q <= (!lat_we && !addr_err) ? mem_data_out : '0;
                resp_err_q   <= addr_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte memory, transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned MEM_BYTES = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        ram_load;
    logic [15:0] mem_Address, mem_data_write, mem_data_out;
    logic        mem_MeM_W, mem_MeM_R;

    always #5 clock = ~clock;

    dmem_arbiter_if p0_bus ();
    dmem_arbiter_if p1_bus ();

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clock          (clock),
        .reset          (reset),
        .p0             (p0_bus),
        .p1             (p1_bus),
        .mem_Address    (mem_Address),
        .mem_data_write (mem_data_write),
        .mem_MeM_W      (mem_MeM_W),
        .mem_MeM_R      (mem_MeM_R),
        .mem_data_out   (mem_data_out)
    );

    // Big-endian byte memory: posedge write, combinational read.
    logic [7:0] ram [64];
    always @(posedge clock) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'(i) ^ 8'hA5;
        end else if (mem_MeM_W && mem_Address <= 16'd62) begin
            ram[mem_Address[5:0]]         <= mem_data_write[15:8];
            ram[mem_Address[5:0] + 6'd1]  <= mem_data_write[7:0];
        end
    end

    always_comb begin
        mem_data_out = 16'h0000;
        if (mem_Address <= 16'd62)
            mem_data_out = {ram[mem_Address[5:0]], ram[mem_Address[5:0] + 6'd1]};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one pending access, timed from its accept cycle.
    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          acc;
    } txn_t;

    txn_t       pend;
    bit         pend_v       = 1'b0;
    logic       m_last_grant = 1'b1;
    logic [15:0] m_addr      = 16'h0;
    logic [15:0] m_wdata     = 16'h0;
    int         free_at      = 0;
    logic [7:0] shadow [64];

    always @(negedge clock) begin : model
        logic e_r0, e_r1, e_w, e_rd, e_v0, e_v1, e_e0, e_e1, ok, inacc, inresp, w;
        logic [15:0] e_d0, e_d1;
        cyc++;
        if (ram_load)
            for (int i = 0; i < 64; i++) shadow[i] = 8'(i) ^ 8'hA5;
        {e_r0, e_r1, e_w, e_rd, e_v0, e_v1, e_e0, e_e1, w} = '0;
        e_d0 = 16'h0;
        e_d1 = 16'h0;
        ok     = pend.addr <= 16'(MEM_BYTES - 2);
        inacc  = pend_v && (cyc == pend.acc + 1);
        inresp = pend_v && (cyc == pend.acc + 2);
        if (!reset) begin
            if (inacc) begin
                e_w  = pend.we && ok;
                e_rd = !pend.we && ok;
                if (e_w) begin
                    shadow[pend.addr[5:0]]        = pend.wdata[15:8];
                    shadow[pend.addr[5:0] + 6'd1] = pend.wdata[7:0];
                end
                pend.rdata = e_rd ? {shadow[pend.addr[5:0]], shadow[pend.addr[5:0] + 6'd1]} : 16'h0;
            end
            if (inresp) begin
                if (pend.port) begin e_v1 = 1'b1; e_d1 = pend.rdata; e_e1 = !ok; end
                else           begin e_v0 = 1'b1; e_d0 = pend.rdata; e_e0 = !ok; end
            end
            if (cyc >= free_at && (p0_bus.valid || p1_bus.valid)) begin
                w    = (p0_bus.valid && p1_bus.valid) ? !m_last_grant : p1_bus.valid;
                e_r0 = !w;
                e_r1 = w;
            end
        end
        check("m_p0_ready", 16'(p0_bus.ready), 16'(e_r0));
        check("m_p1_ready", 16'(p1_bus.ready), 16'(e_r1));
        check("m_mem_W", 16'(mem_MeM_W), 16'(e_w));
        check("m_mem_R", 16'(mem_MeM_R), 16'(e_rd));
        check("m_p0_rvalid", 16'(p0_bus.resp_valid), 16'(e_v0));
        check("m_p1_rvalid", 16'(p1_bus.resp_valid), 16'(e_v1));
        check("m_p0_rdata", p0_bus.resp_rdata, e_d0);
        check("m_p1_rdata", p1_bus.resp_rdata, e_d1);
        check("m_p0_err", 16'(p0_bus.resp_err), 16'(e_e0));
        check("m_p1_err", 16'(p1_bus.resp_err), 16'(e_e1));
        check("m_mem_addr", mem_Address, m_addr);
        check("m_mem_wdata", mem_data_write, m_wdata);
        if (reset) begin
            pend_v       = 1'b0;
            m_last_grant = 1'b1;
            m_addr       = 16'h0;
            m_wdata      = 16'h0;
            free_at      = cyc + 1;
        end else begin
            if (inresp) pend_v = 1'b0;
            if (e_r0 || e_r1) begin
                pend.port    = w;
                pend.we      = w ? p1_bus.we    : p0_bus.we;
                pend.addr    = w ? p1_bus.addr  : p0_bus.addr;
                pend.wdata   = w ? p1_bus.wdata : p0_bus.wdata;
                pend.rdata   = 16'h0;
                pend.acc     = cyc;
                pend_v       = 1'b1;
                m_last_grant = w;
                m_addr       = pend.addr;
                m_wdata      = pend.wdata;
                free_at      = cyc + 3;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic port, input logic v, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (port) begin
            p1_bus.valid = v; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
        end else begin
            p0_bus.valid = v; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
        end
    endtask

    // Issue one request, wait (bounded) for ready and then for the response.
    task automatic do_req(input logic port, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata,
                          output logic err, output int lat, output int en_cnt,
                          output logic [15:0] en_addr);
        bit got, rv;
        got = 0; rv = 0; lat = 0; en_cnt = 0; en_addr = 16'h0; rdata = 16'h0; err = 1'b0;
        set_req(port, 1'b1, we, addr, wdata);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (port ? p1_bus.ready : p0_bus.ready) got = 1;
        end
        if (!got) begin
            check("ready_timeout", 16'd0, 16'd1);
            set_req(port, 1'b0, 1'b0, 16'h0, 16'h0);
            return;
        end
        tick();
        set_req(port, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 6 && !rv; i++) begin
            @(negedge clock);
            lat++;
            if (mem_MeM_W || mem_MeM_R) begin en_cnt++; en_addr = mem_Address; end
            if (port ? p1_bus.resp_valid : p0_bus.resp_valid) begin
                rv    = 1;
                rdata = port ? p1_bus.resp_rdata : p0_bus.resp_rdata;
                err   = port ? p1_bus.resp_err : p0_bus.resp_err;
            end
        end
        if (!rv) check("resp_timeout", 16'd0, 16'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, ea;
        logic        er;
        int          lat, en;
        logic        exp0, exp1;

        reset = 1'b1;
        ram_load = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(); tick(); tick();
        ram_load = 1'b0;
        reset = 1'b0;
        tick();

        // Port 0 write then read-back of address 4
        do_req(1'b0, 1'b1, 16'd4, 16'hBEEF, rd, er, lat, en, ea);
        check("wr4_en_count", 16'(en), 16'd1);
        check("wr4_en_addr", ea, 16'd4);
        check("wr4_err", 16'(er), 16'd0);
        check("wr4_ram_hi", 16'(ram[4]), 16'h00BE);
        check("wr4_ram_lo", 16'(ram[5]), 16'h00EF);
        do_req(1'b0, 1'b0, 16'd4, 16'h0, rd, er, lat, en, ea);
        check("rd4_data", rd, 16'hBEEF);
        check("rd4_err", 16'(er), 16'd0);
        check("rd4_latency", 16'(lat), 16'd2);

        // Port 1 boundary: 62 legal, 63 out of range
        do_req(1'b1, 1'b0, 16'd62, 16'h0, rd, er, lat, en, ea);
        check("rd62_data", rd, 16'h9B9A);
        check("rd62_err", 16'(er), 16'd0);
        do_req(1'b1, 1'b0, 16'd63, 16'h0, rd, er, lat, en, ea);
        check("rd63_data", rd, 16'h0000);
        check("rd63_err", 16'(er), 16'd1);
        check("rd63_no_enable", 16'(en), 16'd0);

        // p1 arrives during p0's response cycle and must wait for IDLE
        set_req(1'b0, 1'b1, 1'b0, 16'd8, 16'h0);
        @(negedge clock);
        check("late_p0_ready", 16'(p0_bus.ready), 16'd1);
        tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        set_req(1'b1, 1'b1, 1'b0, 16'd20, 16'h0);
        @(negedge clock);
        check("late_p1_not_ready_in_resp", 16'(p1_bus.ready), 16'd0);
        check("late_p0_resp", 16'(p0_bus.resp_valid), 16'd1);
        check("late_p0_rdata", p0_bus.resp_rdata, 16'hADAC);
        tick();
        @(negedge clock);
        check("late_p1_ready_idle", 16'(p1_bus.ready), 16'd1);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        @(negedge clock);
        check("late_p1_resp", 16'(p1_bus.resp_valid), 16'd1);
        check("late_p1_rdata", p1_bus.resp_rdata, 16'hB1B0);
        tick();

        // Idle bench: nothing moves
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_quiet", 16'({mem_MeM_W, mem_MeM_R, p0_bus.resp_valid, p1_bus.resp_valid,
                                     p0_bus.ready, p1_bus.ready}), 16'd0);
        end
        tick();

        // Reset during the ACCESS cycle of a write to address 10
        set_req(1'b0, 1'b1, 1'b1, 16'd10, 16'h1234);
        @(negedge clock);
        check("rst_wr_ready", 16'(p0_bus.ready), 16'd1);
        tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_wr_no_enable", 16'(mem_MeM_W), 16'd0);
        tick();
        reset = 1'b0;
        check("rst_ram10", 16'(ram[10]), 16'h00AF);
        check("rst_ram11", 16'(ram[11]), 16'h00AE);

        // Continuous contention straight out of reset: grants 0,1,0,1 every 3 cycles
        set_req(1'b0, 1'b1, 1'b0, 16'd0, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 16'd2, 16'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 0) check("rst_no_resp", 16'(p0_bus.resp_valid), 16'd0);
            exp0 = (i % 3 == 0) && ((i / 3) % 2 == 0);
            exp1 = (i % 3 == 0) && ((i / 3) % 2 == 1);
            check($sformatf("grant_p0_%0d", i), 16'(p0_bus.ready), 16'(exp0));
            check($sformatf("grant_p1_%0d", i), 16'(p1_bus.ready), 16'(exp1));
            if (i % 3 == 2) begin
                check($sformatf("resp_p0_%0d", i), 16'(p0_bus.resp_valid), 16'(((i / 3) % 2) == 0));
                check($sformatf("resp_p1_%0d", i), 16'(p1_bus.resp_valid), 16'(((i / 3) % 2) == 1));
            end
        end
        tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 64-byte data memory (16-bit big-endian words, byte addressed, posedge write, combinational read). It grants port 0 (core load/store) and port 1 (loader/debug) in round-robin order, runs exactly one memory access per grant, and returns a registered read-data/response pulse to the winner. It sits between the requesters and the memory, and is the only driver of the memory's address, data and enable pins.

## Interface
- MEM_BYTES, 64: memory size in bytes; a word access is legal only if Address <= MEM_BYTES-2.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- p0_valid / p1_valid  in  1  request present.
- p0_ready / p1_ready  out  1  request accepted this cycle.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  16  byte address.
- p0_wdata / p1_wdata  in  16  write data.
- p0_resp_valid / p1_resp_valid  out  1  one-cycle response pulse.
- p0_resp_rdata / p1_resp_rdata  out  16  read data; 0 for writes and errors.
- p0_resp_err / p1_resp_err  out  1  out-of-range access; qualified by resp_valid.
- mem_Address  out  16  memory address.
- mem_data_write  out  16  memory write data.
- mem_MeM_W  out  1  memory write enable.
- mem_MeM_R  out  1  memory read enable.
- mem_data_out  in  16  memory read data (combinational).

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any valid is high, choose a winner and assert its ready combinationally in that cycle.
  - At the edge, latch the winner's we, addr and wdata, plus its port id, then go to ACCESS.
  - With no valid, stay in IDLE.
- Arbitration:
  - A last_grant register resets to 1, so port 0 wins the first contention.
  - When both ports are valid, the port other than last_grant wins.
  - When one port is valid, it wins.
  - last_grant updates on every accept.
- ACCESS (one cycle):
  - mem_Address and mem_data_write are driven from the latched values.
  - Range check: err = latched addr > MEM_BYTES-2.
  - Write, no error: mem_MeM_W = 1, which commits at the end-of-cycle edge.
  - Read, no error: mem_MeM_R = 1, and mem_data_out is captured into the response register at the edge.
  - Error: neither enable is asserted, the response data is 0, and err is latched to 1.
  - Next state is RESP.
- RESP (one cycle):
  - The granted port's resp_valid = 1, with rdata and err from the registers.
  - The other port's response outputs are 0.
  - Next state is IDLE.
  - ready stays 0 in this state.
- Outside ACCESS, mem_MeM_W and mem_MeM_R are 0. mem_Address and mem_data_write hold the last latched values.
- ready is never asserted outside IDLE. A requester must hold valid and its payload stable until it sees ready.
- Widths: addresses are 16-bit unsigned, and the range compare uses the full 16 bits. No alignment check is made; odd addresses are legal.

## Timing
- Accept (ready high) at cycle N: memory enable at N+1, resp_valid at N+2, next accept possible at N+3.
- Peak throughput is one access per 3 cycles. Under continuous contention the grants alternate 0,1,0,1.
- Read latency from accept to data is 2 cycles. The write commits at the end of cycle N+1.
- Reset, applied at any edge:
  - State goes to IDLE, last_grant to 1, and the response registers to 0.
  - mem_MeM_W and mem_MeM_R are gated by !reset combinationally, so an ACCESS cycle that coincides with reset performs no write.
  - An in-flight transaction is dropped with no response.
- Reset values: all ready, resp_valid, resp_rdata, resp_err, mem_MeM_W and mem_MeM_R = 0. mem_Address = 0 and mem_data_write = 0.
- A valid that arrives while the FSM is in ACCESS or RESP waits. It is evaluated in the next IDLE cycle.

## Test plan
- Port 0 writes 0xBEEF to address 4, then reads address 4. Required: mem_MeM_W pulses for one cycle with mem_Address = 4; the read's p0_resp_rdata = 0xBEEF, err = 0, arriving 2 cycles after ready.
- Both ports valid from reset, each issuing reads. Required: grants go p0, p1, p0, p1, with accepts exactly 3 cycles apart; resp_valid appears only on the granted port.
- Port 1 reads address 62 and then address 63. Required: 62 returns data with err = 0; 63 returns resp_err = 1 and rdata = 0, with no memory enable asserted.
- Reset asserted during the ACCESS cycle of a write of 0x1234 to address 10. Required: the memory byte at address 10 is unchanged, no resp_valid is seen, and after reset the first contention is won by port 0.
- p1_valid rises while a port 0 transaction is in RESP. Required: p1_ready asserts in the following IDLE cycle and not earlier; the payload sampled is the one held stable.
- Idle bench with no valids for 20 cycles. Required: all enables and responses stay 0, and the FSM stays in IDLE.
